parking_controller: RTL and testbench

- Registered Moore FSM for a smart-parking access point.
- User session: request → token authentication against a system token → one grant cycle → entry of parking time.
- On capture, publishes the accepted time word on data_Q and the computed fee on data_P.
- Sits between the user keypad/time-entry front end and the display/billing logic; a single clock domain.

---
 rtl/parking_pkg.sv | 16 +
 rtl/parking_fee_calc.sv | 19 +
 rtl/parking_controller.sv | 90 +++++++++
 tb/tb_parking_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking access controller.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AUTH  = 3'd1,
    ST_GRANT = 3'd2,
    ST_TIME  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [7:0] DEF_RATE     = 8'd10;
  localparam logic [7:0] DEF_ERR_CODE = 8'hEE;

endpackage

// File: rtl/parking_fee_calc.sv
// Parking fee: hours x RATE, widened to 12 bits and clamped to 8'hFF.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter logic [7:0] RATE = DEF_RATE
) (
  input  logic [3:0] hours_i,
  output logic [7:0] fee_o
);

  logic [11:0] prod;

  // 15 * 255 = 3825 fits in 12 bits, so the product never wraps before clamping
  always_comb begin
    prod  = {8'd0, hours_i} * {4'd0, RATE};
    fee_o = (prod > 12'd255) ? 8'hFF : prod[7:0];
  end

endmodule

// File: rtl/parking_controller.sv
// Moore FSM for a parking access point: request, token auth, grant gap,
// time capture; publishes the captured time word and its fee.
module parking_controller
  import parking_pkg::*;
#(
  parameter logic [7:0] RATE     = DEF_RATE,
  parameter logic [7:0] ERR_CODE = DEF_ERR_CODE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] system_token,
  input  logic       request,
  input  logic [7:0] TimeData,
  input  logic       confirm,
  input  logic [2:0] user_token,
  output logic [7:0] data_Q,
  output logic [7:0] data_P
);

  state_e     state_q, state_d;
  logic [7:0] dq_q, dq_d;
  logic [7:0] dp_q, dp_d;
  logic [7:0] fee;

  parking_fee_calc #(.RATE(RATE)) u_fee (
    .hours_i (TimeData[3:0]),
    .fee_o   (fee)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dq_q    <= 8'd0;
      dp_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    dp_d    = dp_q;
    // Dropping request aborts any session and wins over every other transition
    if (state_q != ST_IDLE && !request) begin
      state_d = ST_IDLE;
      dq_d    = 8'd0;
      dp_d    = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dq_d = 8'd0;
          dp_d = 8'd0;
          if (request) state_d = ST_AUTH;
        end
        ST_AUTH: begin
          if (confirm) begin
            if (user_token == system_token) begin
              state_d = ST_GRANT;
            end else begin
              state_d = ST_ERROR;
              dq_d    = ERR_CODE;
              dp_d    = 8'd0;
            end
          end
        end
        ST_GRANT: state_d = ST_TIME;
        ST_TIME: begin
          if (confirm) begin
            state_d = ST_DONE;
            dq_d    = TimeData;
            dp_d    = fee;
          end
        end
        ST_DONE, ST_ERROR: ;
        default: begin
          state_d = ST_IDLE;
          dq_d    = 8'd0;
          dp_d    = 8'd0;
        end
      endcase
    end
  end

  assign data_Q = dq_q;
  assign data_P = dp_q;

endmodule

// File: tb/tb_parking_controller.sv
// Bench for parking_controller: directed vector table, async reset cases,
// then random sessions against a session-level reference model.
module tb_parking_controller;

  logic       clock, reset;
  logic [2:0] system_token, user_token;
  logic       request, confirm;
  logic [7:0] TimeData;
  logic [7:0] q10, p10, q20, p20;

  int checks = 0;
  int errors = 0;

  parking_controller #(.RATE(8'd10), .ERR_CODE(8'hEE)) dut10 (
    .clock(clock), .reset(reset), .system_token(system_token), .request(request),
    .TimeData(TimeData), .confirm(confirm), .user_token(user_token),
    .data_Q(q10), .data_P(p10)
  );

  parking_controller #(.RATE(8'd20), .ERR_CODE(8'hEE)) dut20 (
    .clock(clock), .reset(reset), .system_token(system_token), .request(request),
    .TimeData(TimeData), .confirm(confirm), .user_token(user_token),
    .data_Q(q20), .data_P(p20)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       req;
    logic       conf;
    logic [2:0] ut;
    logic [2:0] st;
    logic [7:0] td;
    logic [7:0] eq;
    logic [7:0] ep10;
    logic [7:0] ep20;
  } vec_t;

  vec_t tbl[$];

  // Reference: session progress plus what the display should show.
  // progress: 0 no session, 1 awaiting token, 2 grant gap, 3 awaiting time,
  // 4 captured, 5 rejected
  int         progress;
  logic [7:0] m_q, m_p10, m_p20;

  function automatic logic [7:0] fee_of(input logic [7:0] td, input int rate);
    int f;
    f = int'(td[3:0]) * rate;
    return (f > 255) ? 8'hFF : 8'(f);
  endfunction

  task automatic model_reset();
    progress = 0; m_q = 8'd0; m_p10 = 8'd0; m_p20 = 8'd0;
  endtask

  task automatic model_edge();
    if (progress != 0 && !request) begin
      model_reset();
    end else if (progress == 0) begin
      if (request) progress = 1;
    end else if (progress == 1) begin
      if (confirm) begin
        if (user_token == system_token) progress = 2;
        else begin progress = 5; m_q = 8'hEE; m_p10 = 8'd0; m_p20 = 8'd0; end
      end
    end else if (progress == 2) begin
      progress = 3;
    end else if (progress == 3 && confirm) begin
      progress = 4;
      m_q = TimeData; m_p10 = fee_of(TimeData, 10); m_p20 = fee_of(TimeData, 20);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic conf, input logic [2:0] ut,
                       input logic [2:0] st, input logic [7:0] td);
    request = req; confirm = conf; user_token = ut; system_token = st; TimeData = td;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic add(input logic req, input logic conf, input logic [2:0] ut,
                     input logic [7:0] td, input logic [7:0] eq,
                     input logic [7:0] e10, input logic [7:0] e20);
    tbl.push_back({req, conf, ut, 3'd5, td, eq, e10, e20});
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk({tag, "_q10"}, q10, 8'd0);
    chk({tag, "_p10"}, p10, 8'd0);
    chk({tag, "_p20"}, p20, 8'd0);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Directed session table: inputs before the edge, outputs after it
    add(1, 1, 3'd5, 8'hF2, 8'h00, 8'd0,  8'd0);   // IDLE->AUTH
    add(1, 1, 3'd5, 8'hF2, 8'h00, 8'd0,  8'd0);   // AUTH->GRANT
    add(1, 1, 3'd5, 8'hF2, 8'h00, 8'd0,  8'd0);   // GRANT->TIME
    add(1, 1, 3'd5, 8'hF2, 8'hF2, 8'd20, 8'd40);  // capture
    add(1, 1, 3'd5, 8'h33, 8'hF2, 8'd20, 8'd40);  // no re-capture
    add(1, 0, 3'd5, 8'h33, 8'hF2, 8'd20, 8'd40);
    add(0, 0, 3'd5, 8'h33, 8'h00, 8'd0,  8'd0);   // drop in DONE
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // AUTH
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // AUTH waits
    add(1, 1, 3'd3, 8'h00, 8'hEE, 8'd0,  8'd0);   // mismatch -> ERROR
    add(1, 0, 3'd5, 8'h00, 8'hEE, 8'd0,  8'd0);
    add(1, 1, 3'd5, 8'h11, 8'hEE, 8'd0,  8'd0);   // ERROR sticky
    add(0, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // AUTH
    add(1, 1, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // GRANT
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // TIME
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // TIME waits
    add(0, 1, 3'd5, 8'h12, 8'h00, 8'd0,  8'd0);   // drop in TIME
    add(1, 0, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // AUTH
    add(1, 1, 3'd5, 8'h00, 8'h00, 8'd0,  8'd0);   // GRANT
    add(1, 1, 3'd5, 8'h4F, 8'h00, 8'd0,  8'd0);   // TIME, confirm ignored in GRANT
    add(1, 1, 3'd5, 8'h4F, 8'h4F, 8'd150, 8'hFF); // 300 saturates
    add(1, 0, 3'd5, 8'h00, 8'h4F, 8'd150, 8'hFF);

    model_reset();
    reset = 1'b0;
    drive(1, 1, 3'd5, 3'd5, 8'hF2);
    #17;
    chk("rst_q10", q10, 8'd0);
    chk("rst_p10", p10, 8'd0);
    chk("rst_p20", p20, 8'd0);
    #13 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].conf, tbl[i].ut, tbl[i].st, tbl[i].td);
      step();
      chk($sformatf("vec%0d_q10", i), q10, tbl[i].eq);
      chk($sformatf("vec%0d_p10", i), p10, tbl[i].ep10);
      chk($sformatf("vec%0d_q20", i), q20, tbl[i].eq);
      chk($sformatf("vec%0d_p20", i), p20, tbl[i].ep20);
    end

    // Async reset mid-cycle while in DONE
    async_reset_check("arst_done");
    drive(0, 0, 3'd0, 3'd0, 8'h00);
    step();
    chk("post_arst_q10", q10, 8'd0);
    drive(1, 1, 3'd2, 3'd2, 8'h0C);
    step(); step(); step(); step();
    chk("restart_q10", q10, 8'h0C);
    chk("restart_p10", p10, 8'd120);
    chk("restart_p20", p20, 8'd240);
    drive(1, 1, 3'd2, 3'd2, 8'h0D);
    step(); chk("drop_prep_q10", q10, 8'h0C);
    drive(0, 1, 3'd2, 3'd2, 8'h0D);
    step(); chk("drop_idle_q10", q10, 8'd0);
    drive(1, 1, 3'd2, 3'd2, 8'h0D);
    step(); step(); step(); step();
    chk("sat_edge_p20", p20, 8'hFF);
    chk("sat_edge_p10", p10, 8'd130);

    // Random sessions vs reference model
    for (int n = 0; n < 600; n++) begin
      logic [2:0] ut;
      ut = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), ut,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ut,
            8'($urandom_range(0, 255)));
      step();
      chk("rnd_q10", q10, m_q);
      chk("rnd_p10", p10, m_p10);
      chk("rnd_q20", q20, m_q);
      chk("rnd_p20", p20, m_p20);
      if ($urandom_range(0, 59) == 0) async_reset_check("rnd_arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
